// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - states, opcodes, condition codes and strobe bundle for the run controller
package riscv_ctrl_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LOAD  = 3'd1;
   localparam logic [2:0] ST_CLEAR = 3'd2;
   localparam logic [2:0] ST_RUN   = 3'd3;
   localparam logic [2:0] ST_HALT  = 3'd4;

   localparam logic [4:0] OP_ALU = 5'b00000;
   localparam logic [4:0] OP_LHI = 5'b00001;
   localparam logic [4:0] OP_LLI = 5'b00010;
   localparam logic [4:0] OP_LDR = 5'b00011;
   localparam logic [4:0] OP_STR = 5'b00101;
   localparam logic [4:0] OP_MOV = 5'b00110;
   localparam logic [4:0] OP_JMP = 5'b10000;
   localparam logic [4:0] OP_JR  = 5'b10001;
   localparam logic [4:0] OP_JAL = 5'b10010;
   localparam logic [4:0] OP_BCC = 5'b11000;
   localparam logic [4:0] OP_OUT = 5'b11100;
   localparam logic [4:0] OP_HLT = 5'b11111;

   localparam logic [1:0] FN_ADD = 2'b00;
   localparam logic [1:0] FN_SUB = 2'b01;
   localparam logic [1:0] FN_ADC = 2'b10;
   localparam logic [1:0] FN_SBB = 2'b11;

   localparam logic [2:0] CC_EQ = 3'b000;
   localparam logic [2:0] CC_NE = 3'b001;
   localparam logic [2:0] CC_CS = 3'b010;
   localparam logic [2:0] CC_CC = 3'b011;
   localparam logic [2:0] CC_MI = 3'b100;
   localparam logic [2:0] CC_PL = 3'b101;
   localparam logic [2:0] CC_VS = 3'b110;
   localparam logic [2:0] CC_AL = 3'b111;

   typedef struct packed {
      logic rf_write_en;
      logic data_write_en;
      logic mem_rf;
      logic alu_rf;
      logic rm_rf;
      logic pc_rf;
      logic lhi;
      logic lli;
      logic src_alu_b;
      logic src_read_b;
      logic adc;
      logic sub;
      logic sbb;
      logic jmp;
      logic branch;
      logic label_pc;
      logic rm_pc;
      logic rd_pc;
      logic out_r;
   } strobes_t;

   function automatic logic cond_holds(input logic [2:0] cc, input logic n, input logic z,
                                       input logic c, input logic v);
      case (cc)
         CC_EQ:   cond_holds = z;
         CC_NE:   cond_holds = !z;
         CC_CS:   cond_holds = c;
         CC_CC:   cond_holds = !c;
         CC_MI:   cond_holds = n;
         CC_PL:   cond_holds = !n;
         CC_VS:   cond_holds = v;
         default: cond_holds = 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/riscv_instr_decoder.sv
// rtl/riscv_instr_decoder.sv - combinational instruction + NZCV to datapath strobe decode
module riscv_instr_decoder
   import riscv_ctrl_pkg::*;
(
   input  logic [15:0] instr,
   input  logic        flag_n,
   input  logic        flag_z,
   input  logic        flag_c,
   input  logic        flag_v,
   output strobes_t    strobes,
   output logic        is_alu,
   output logic        is_hlt
);

   logic [4:0] op;
   logic [1:0] fn;
   logic       unused_operand_bits;

   assign op = instr[15:11];
   assign fn = instr[1:0];
   // Register/immediate operand fields go straight to the datapath, not through here.
   assign unused_operand_bits = ^instr[7:2];

   always_comb begin
      strobes = '0;
      is_alu  = 1'b0;
      is_hlt  = 1'b0;
      case (op)
         OP_ALU: begin
            is_alu              = 1'b1;
            strobes.alu_rf      = 1'b1;
            strobes.rf_write_en = 1'b1;
            strobes.sub         = (fn == FN_SUB);
            strobes.adc         = (fn == FN_ADC);
            strobes.sbb         = (fn == FN_SBB);
         end
         OP_LHI: begin
            strobes.lhi         = 1'b1;
            strobes.src_read_b  = 1'b1;
            strobes.rf_write_en = 1'b1;
         end
         OP_LLI: begin
            strobes.lli         = 1'b1;
            strobes.rf_write_en = 1'b1;
         end
         OP_LDR: begin
            strobes.src_alu_b   = 1'b1;
            strobes.mem_rf      = 1'b1;
            strobes.rf_write_en = 1'b1;
         end
         OP_STR: begin
            strobes.src_alu_b     = 1'b1;
            strobes.src_read_b    = 1'b1;
            strobes.data_write_en = 1'b1;
         end
         OP_MOV: begin
            strobes.rm_rf       = 1'b1;
            strobes.rf_write_en = 1'b1;
         end
         OP_JMP: begin
            strobes.jmp      = 1'b1;
            strobes.label_pc = 1'b1;
         end
         OP_JR:  strobes.rm_pc = 1'b1;
         OP_JAL: begin
            strobes.label_pc    = 1'b1;
            strobes.pc_rf       = 1'b1;
            strobes.rf_write_en = 1'b1;
         end
         OP_BCC: strobes.branch = cond_holds(instr[10:8], flag_n, flag_z, flag_c, flag_v);
         OP_OUT: strobes.out_r  = 1'b1;
         OP_HLT: is_hlt         = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/riscv_run_controller.sv
// rtl/riscv_run_controller.sv - load/clear/run/halt sequencer driving the single-cycle datapath
module riscv_run_controller
   import riscv_ctrl_pkg::*;
#(
   parameter int AW         = 16,
   parameter int MAX_WORDS  = 256,
   parameter int CNT_W      = 16,
   parameter int MAX_CYCLES = 16'hFFFF
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             load_start,
   input  logic             load_target,
   input  logic             ld_valid,
   input  logic [15:0]      ld_data,
   input  logic             ld_last,
   output logic             ld_ready,
   input  logic             run_start,
   input  logic             stop_req,
   input  logic [15:0]      mem_instr_out,
   input  logic             Pre_C,
   input  logic             Pre_V,
   input  logic             Pre_Z,
   input  logic             Pre_N,
   output logic             test_normal,
   output logic             ext_instr_we,
   output logic             ext_data_write_en,
   output logic [AW-1:0]    ext_instr_addr,
   output logic [AW-1:0]    ext_data_addr,
   output logic [15:0]      ext_instr_data,
   output logic [15:0]      ext_data_data,
   output logic             dp_clr,
   output logic             flag_HLT,
   output logic             RF_write_en,
   output logic             data_write_en,
   output logic             flag_mem_RF,
   output logic             flag_ALU_RF,
   output logic             flag_Rm_RF,
   output logic             flag_PC_RF,
   output logic             LHI,
   output logic             LLI,
   output logic             Src_ALU_B,
   output logic             Src_Read_B,
   output logic             ADC,
   output logic             SUB,
   output logic             SBB,
   output logic             JMP,
   output logic             BRANCH,
   output logic             flag_label_PC,
   output logic             flag_Rm_PC,
   output logic             flag_Rd_PC,
   output logic             flag_OutR,
   output logic             busy,
   output logic             halted,
   output logic             timeout,
   output logic [CNT_W-1:0] cycle_count
);

   localparam logic [AW-1:0]    LAST_WORD = AW'(MAX_WORDS - 1);
   localparam logic [CNT_W-1:0] WD_LAST   = CNT_W'(MAX_CYCLES - 1);
   localparam bit               WD_EN     = (MAX_CYCLES != 0);

   logic [2:0]    state;
   logic          load_sel;
   logic [AW-1:0] word_cnt;
   logic          nf, zf, cf, vf;
   strobes_t      dec_strb, run_strb;
   logic          is_alu, is_hlt, in_run, wd_hit;

   riscv_instr_decoder u_dec (
      .instr   (mem_instr_out),
      .flag_n  (nf),
      .flag_z  (zf),
      .flag_c  (cf),
      .flag_v  (vf),
      .strobes (dec_strb),
      .is_alu  (is_alu),
      .is_hlt  (is_hlt)
   );

   assign in_run      = (state == ST_RUN);
   assign wd_hit      = WD_EN && (cycle_count == WD_LAST);
   assign ld_ready    = (state == ST_LOAD);
   assign dp_clr      = (state == ST_CLEAR);
   assign test_normal = !(in_run || dp_clr);
   assign flag_HLT    = in_run && !is_hlt;
   assign busy        = (state != ST_IDLE) && (state != ST_HALT);
   assign halted      = (state == ST_HALT);
   assign run_strb    = in_run ? dec_strb : '0;

   assign RF_write_en   = run_strb.rf_write_en;
   assign data_write_en = run_strb.data_write_en;
   assign flag_mem_RF   = run_strb.mem_rf;
   assign flag_ALU_RF   = run_strb.alu_rf;
   assign flag_Rm_RF    = run_strb.rm_rf;
   assign flag_PC_RF    = run_strb.pc_rf;
   assign LHI           = run_strb.lhi;
   assign LLI           = run_strb.lli;
   assign Src_ALU_B     = run_strb.src_alu_b;
   assign Src_Read_B    = run_strb.src_read_b;
   assign ADC           = run_strb.adc;
   assign SUB           = run_strb.sub;
   assign SBB           = run_strb.sbb;
   assign JMP           = run_strb.jmp;
   assign BRANCH        = run_strb.branch;
   assign flag_label_PC = run_strb.label_pc;
   assign flag_Rm_PC    = run_strb.rm_pc;
   assign flag_Rd_PC    = run_strb.rd_pc;
   assign flag_OutR     = run_strb.out_r;

   always_ff @(posedge clk) begin
      if (clr) begin
         state             <= ST_IDLE;
         load_sel          <= 1'b0;
         word_cnt          <= '0;
         ext_instr_we      <= 1'b0;
         ext_data_write_en <= 1'b0;
         ext_instr_addr    <= '0;
         ext_data_addr     <= '0;
         ext_instr_data    <= '0;
         ext_data_data     <= '0;
         {nf, zf, cf, vf}  <= 4'b0000;
         cycle_count       <= '0;
         timeout           <= 1'b0;
      end else begin
         ext_instr_we      <= 1'b0;
         ext_data_write_en <= 1'b0;
         case (state)
            ST_IDLE, ST_HALT: begin
               if (load_start) begin
                  state    <= ST_LOAD;
                  load_sel <= load_target;
                  word_cnt <= '0;
               end else if (run_start) begin
                  state <= ST_CLEAR;
               end
            end
            ST_LOAD: begin
               // ld_ready is high throughout LOAD, so ld_valid alone marks a handshake.
               if (ld_valid) begin
                  if (load_sel) begin
                     ext_data_write_en <= 1'b1;
                     ext_data_addr     <= word_cnt;
                     ext_data_data     <= ld_data;
                  end else begin
                     ext_instr_we   <= 1'b1;
                     ext_instr_addr <= word_cnt;
                     ext_instr_data <= ld_data;
                  end
                  word_cnt <= word_cnt + 1'b1;
                  if (ld_last || word_cnt == LAST_WORD) state <= ST_IDLE;
               end
            end
            ST_CLEAR: begin
               cycle_count      <= '0;
               {nf, zf, cf, vf} <= 4'b0000;
               timeout          <= 1'b0;
               state            <= ST_RUN;
            end
            ST_RUN: begin
               if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
               if (is_alu) {nf, zf, cf, vf} <= {Pre_N, Pre_Z, Pre_C, Pre_V};
               if (is_hlt || stop_req || wd_hit) state <= ST_HALT;
               if (wd_hit) timeout <= 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_run_controller.sv
// tb/tb_riscv_run_controller.sv - scoreboard bench for the run controller
`timescale 1ns/1ps
module tb_riscv_run_controller;

   localparam int AW = 16;
   localparam int MW = 16;
   localparam int CW = 16;
   localparam int MC = 10;

   localparam logic [18:0] S_RF   = 19'd1 << 18;
   localparam logic [18:0] S_DWE  = 19'd1 << 17;
   localparam logic [18:0] S_MEM  = 19'd1 << 16;
   localparam logic [18:0] S_ALU  = 19'd1 << 15;
   localparam logic [18:0] S_RM   = 19'd1 << 14;
   localparam logic [18:0] S_PCRF = 19'd1 << 13;
   localparam logic [18:0] S_LHI  = 19'd1 << 12;
   localparam logic [18:0] S_LLI  = 19'd1 << 11;
   localparam logic [18:0] S_SAB  = 19'd1 << 10;
   localparam logic [18:0] S_SRB  = 19'd1 << 9;
   localparam logic [18:0] S_ADC  = 19'd1 << 8;
   localparam logic [18:0] S_SUB  = 19'd1 << 7;
   localparam logic [18:0] S_SBB  = 19'd1 << 6;
   localparam logic [18:0] S_JMP  = 19'd1 << 5;
   localparam logic [18:0] S_BR   = 19'd1 << 4;
   localparam logic [18:0] S_LBL  = 19'd1 << 3;
   localparam logic [18:0] S_RMPC = 19'd1 << 2;
   localparam logic [18:0] S_OUT  = 19'd1 << 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic clr, load_start, load_target, ld_valid, ld_last, ld_ready, run_start, stop_req;
   logic [15:0] ld_data, mem_instr_out;
   logic Pre_C, Pre_V, Pre_Z, Pre_N;
   logic test_normal, ext_instr_we, ext_data_write_en, dp_clr, flag_HLT;
   logic [AW-1:0] ext_instr_addr, ext_data_addr;
   logic [15:0] ext_instr_data, ext_data_data;
   logic RF_write_en, data_write_en, flag_mem_RF, flag_ALU_RF, flag_Rm_RF, flag_PC_RF;
   logic LHI, LLI, Src_ALU_B, Src_Read_B, ADC, SUB, SBB, JMP, BRANCH;
   logic flag_label_PC, flag_Rm_PC, flag_Rd_PC, flag_OutR, busy, halted, timeout;
   logic [CW-1:0] cycle_count;
   logic [18:0] strb;

   int checks = 0;
   int errors = 0;
   logic [15:0] words[$];
   logic [32:0] wr_q[$];
   logic [18:0] exp_q[$];
   logic [15:0] prog[32];
   logic [18:0] exp_strb[32];
   logic [3:0]  pre[32];

   riscv_run_controller #(.AW(AW), .MAX_WORDS(MW), .CNT_W(CW), .MAX_CYCLES(MC)) dut (
      .clk(clk), .clr(clr), .load_start(load_start), .load_target(load_target),
      .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
      .run_start(run_start), .stop_req(stop_req), .mem_instr_out(mem_instr_out),
      .Pre_C(Pre_C), .Pre_V(Pre_V), .Pre_Z(Pre_Z), .Pre_N(Pre_N),
      .test_normal(test_normal), .ext_instr_we(ext_instr_we), .ext_data_write_en(ext_data_write_en),
      .ext_instr_addr(ext_instr_addr), .ext_data_addr(ext_data_addr),
      .ext_instr_data(ext_instr_data), .ext_data_data(ext_data_data),
      .dp_clr(dp_clr), .flag_HLT(flag_HLT),
      .RF_write_en(RF_write_en), .data_write_en(data_write_en), .flag_mem_RF(flag_mem_RF),
      .flag_ALU_RF(flag_ALU_RF), .flag_Rm_RF(flag_Rm_RF), .flag_PC_RF(flag_PC_RF),
      .LHI(LHI), .LLI(LLI), .Src_ALU_B(Src_ALU_B), .Src_Read_B(Src_Read_B),
      .ADC(ADC), .SUB(SUB), .SBB(SBB), .JMP(JMP), .BRANCH(BRANCH),
      .flag_label_PC(flag_label_PC), .flag_Rm_PC(flag_Rm_PC), .flag_Rd_PC(flag_Rd_PC),
      .flag_OutR(flag_OutR), .busy(busy), .halted(halted), .timeout(timeout),
      .cycle_count(cycle_count)
   );

   assign strb = {RF_write_en, data_write_en, flag_mem_RF, flag_ALU_RF, flag_Rm_RF, flag_PC_RF,
                  LHI, LLI, Src_ALU_B, Src_Read_B, ADC, SUB, SBB, JMP, BRANCH,
                  flag_label_PC, flag_Rm_PC, flag_Rd_PC, flag_OutR};

   task automatic clear_prog();
      for (int i = 0; i < 32; i++) begin
         prog[i] = 16'h0000; exp_strb[i] = '0; pre[i] = 4'h0;
      end
   endtask

   // Drives a burst from words[]; writes expected at each handshake are checked when they surface.
   task automatic do_load(input string name, input logic target, input int n, input bit gaps,
                          output int writes, output logic [AW-1:0] last_addr);
      logic [32:0] e, o;
      int idx, acc, cyc;
      bit active;
      load_start = 1'b1; load_target = target;
      @(posedge clk); #1;
      load_start = 1'b0;
      idx = 0; acc = 0; cyc = 0; active = 1'b1; writes = 0; last_addr = '0;
      while ((active || wr_q.size() != 0) && cyc < 2000) begin
         ld_valid = (idx < n) && (!gaps || (cyc % 2 == 0));
         ld_data  = (idx < n) ? words[idx] : 16'h0000;
         ld_last  = (idx == n - 1);
         @(negedge clk);
         checks++;
         if (ld_ready !== active) begin
            errors++; $display("FAIL %s ld_ready cyc %0d got %b exp %b", name, cyc, ld_ready, active);
         end
         if (ext_instr_we || ext_data_write_en) begin
            o = ext_data_write_en ? {1'b1, ext_data_addr, ext_data_data} : {1'b0, ext_instr_addr, ext_instr_data};
            e = (wr_q.size() != 0) ? wr_q.pop_front() : 33'h1_ffff_ffff;
            checks++;
            if (o !== e || (ext_instr_we && ext_data_write_en)) begin
               errors++; $display("FAIL %s write got %h exp %h", name, o, e);
            end
            writes++; last_addr = o[31:16];
         end
         if (active && ld_valid) begin
            wr_q.push_back({target, AW'(acc), ld_data});
            acc++; idx++;
            if (ld_last || acc == MW) active = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      ld_valid = 1'b0; ld_last = 1'b0; wr_q.delete();
      checks++;
      if (cyc >= 2000) begin errors++; $display("FAIL %s load did not complete", name); end
   endtask

   task automatic start_run(input string name);
      run_start = 1'b1;
      @(posedge clk); #1;
      run_start = 1'b0;
      @(negedge clk);
      checks++;
      if ({dp_clr, test_normal, busy} !== 3'b101) begin
         errors++; $display("FAIL %s clear cycle got %b exp 101", name, {dp_clr, test_normal, busy});
      end
      @(posedge clk); #1;
   endtask

   task automatic run_cycles(input string name, input int n);
      int pc;
      logic [18:0] e;
      pc = 0;
      for (int k = 0; k < n; k++) begin
         mem_instr_out = prog[pc];
         {Pre_N, Pre_Z, Pre_C, Pre_V} = pre[k];
         exp_q.push_back(exp_strb[k]);
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (strb !== e) begin
            errors++; $display("FAIL %s strobes cyc %0d got %h exp %h", name, k, strb, e);
         end
         checks++;
         if (flag_HLT !== (prog[pc][15:11] != 5'b11111)) begin
            errors++; $display("FAIL %s flag_HLT cyc %0d got %b", name, k, flag_HLT);
         end
         if (prog[pc][15:11] == 5'b10000) pc = int'(prog[pc][10:0]); else pc++;
         @(posedge clk); #1;
      end
      mem_instr_out = 16'h0000;
      {Pre_N, Pre_Z, Pre_C, Pre_V} = 4'h0;
   endtask

   task automatic test_reset();
      clr = 1'b1;
      repeat (2) @(posedge clk);
      #1 clr = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, halted, timeout, flag_HLT, dp_clr, ld_ready, ext_instr_we, ext_data_write_en, test_normal} !== 9'b000000001) begin
         errors++; $display("FAIL reset flags got %b exp 000000001",
            {busy, halted, timeout, flag_HLT, dp_clr, ld_ready, ext_instr_we, ext_data_write_en, test_normal});
      end
      checks++;
      if (strb !== 19'h0 || cycle_count !== 16'd0) begin
         errors++; $display("FAIL reset strobes/count got %h/%0d exp 0/0", strb, cycle_count);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_instr_load();
      int w; logic [AW-1:0] la;
      words = '{16'h1900, 16'hE020, 16'h1A01, 16'hE040, 16'h0328, 16'hE060, 16'hF800};
      do_load("instr_load", 1'b0, 7, 1'b0, w, la);
      @(negedge clk);
      checks++;
      if (w != 7 || la !== 16'd6) begin errors++; $display("FAIL instr_load count got %0d/%0d exp 7/6", w, la); end
      checks++;
      if (ld_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL instr_load idle got %b%b exp 00", ld_ready, busy); end
      @(posedge clk); #1;
   endtask

   task automatic test_data_run();
      int w; logic [AW-1:0] la;
      words = '{16'h1234, 16'h4321};
      do_load("data_load", 1'b1, 2, 1'b0, w, la);
      clear_prog();
      prog[0] = 16'h1900; prog[1] = 16'hE020; prog[2] = 16'h1A01; prog[3] = 16'hE040;
      prog[4] = 16'h0328; prog[5] = 16'hE060; prog[6] = 16'hF800;
      exp_strb[0] = S_RF | S_MEM | S_SAB; exp_strb[1] = S_OUT;
      exp_strb[2] = S_RF | S_MEM | S_SAB; exp_strb[3] = S_OUT;
      exp_strb[4] = S_RF | S_ALU;         exp_strb[5] = S_OUT;
      start_run("data_run");
      run_cycles("data_run", 7);
      @(negedge clk);
      checks++;
      if ({halted, flag_HLT, busy, timeout} !== 4'b1000 || cycle_count !== 16'd7 || strb !== 19'h0) begin
         errors++; $display("FAIL data_run halt got %b cnt %0d strb %h exp 1000 7 0",
            {halted, flag_HLT, busy, timeout}, cycle_count, strb);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_branch();
      clear_prog();
      prog[0] = 16'h0000; prog[1] = 16'hC000; prog[2] = 16'hC700; prog[3] = 16'hF800;
      pre[0] = 4'b0100;
      exp_strb[0] = S_RF | S_ALU; exp_strb[1] = S_BR; exp_strb[2] = S_BR;
      start_run("branch_z");
      run_cycles("branch_z", 4);
      clear_prog();
      prog[0] = 16'h0001; prog[1] = 16'hC000; prog[2] = 16'hC100; prog[3] = 16'hC700; prog[4] = 16'hF800;
      for (int i = 1; i < 5; i++) pre[i] = 4'b0100;
      exp_strb[0] = S_RF | S_ALU | S_SUB; exp_strb[2] = S_BR; exp_strb[3] = S_BR;
      start_run("branch_nz");
      run_cycles("branch_nz", 5);
      @(negedge clk);
      checks++;
      if (halted !== 1'b1 || cycle_count !== 16'd5) begin
         errors++; $display("FAIL branch_nz halt got %b cnt %0d exp 1 5", halted, cycle_count);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_decode();
      clear_prog();
      prog[0] = 16'h0800; prog[1] = 16'h1000; prog[2] = 16'h2800; prog[3] = 16'h3000; prog[4] = 16'h8801;
      prog[5] = 16'h9000; prog[6] = 16'h3800; prog[7] = 16'h0002; prog[8] = 16'h0003; prog[9] = 16'hF800;
      exp_strb[0] = S_RF | S_LHI | S_SRB; exp_strb[1] = S_RF | S_LLI;
      exp_strb[2] = S_SAB | S_SRB | S_DWE; exp_strb[3] = S_RF | S_RM;
      exp_strb[4] = S_RMPC; exp_strb[5] = S_RF | S_LBL | S_PCRF;
      exp_strb[7] = S_RF | S_ALU | S_ADC; exp_strb[8] = S_RF | S_ALU | S_SBB;
      start_run("decode");
      run_cycles("decode", 10);
      @(negedge clk);
      checks++;
      // HLT lands on the watchdog's last cycle, so both causes coincide here.
      if ({halted, timeout} !== 2'b11 || cycle_count !== 16'd10) begin
         errors++; $display("FAIL decode hlt+wd got %b cnt %0d exp 11 10", {halted, timeout}, cycle_count);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_watchdog();
      clear_prog();
      prog[0] = 16'h8000;
      for (int i = 0; i < 10; i++) exp_strb[i] = S_JMP | S_LBL;
      start_run("watchdog");
      run_cycles("watchdog", 10);
      @(negedge clk);
      checks++;
      if ({halted, timeout, flag_HLT} !== 3'b110 || cycle_count !== 16'd10) begin
         errors++; $display("FAIL watchdog got %b cnt %0d exp 110 10", {halted, timeout, flag_HLT}, cycle_count);
      end
      @(posedge clk); #1;
      clear_prog();
      prog[0] = 16'hF800;
      start_run("rerun");
      run_cycles("rerun", 1);
      @(negedge clk);
      checks++;
      if ({halted, timeout} !== 2'b10 || cycle_count !== 16'd1) begin
         errors++; $display("FAIL rerun got %b cnt %0d exp 10 1", {halted, timeout}, cycle_count);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_stop();
      clear_prog();
      for (int i = 0; i < 8; i++) begin prog[i] = 16'hE000; exp_strb[i] = S_OUT; end
      start_run("stop");
      run_cycles("stop", 2);
      mem_instr_out = 16'hE000; stop_req = 1'b1;
      @(negedge clk);
      checks++;
      if (strb !== S_OUT || flag_HLT !== 1'b1) begin
         errors++; $display("FAIL stop cycle got %h %b exp %h 1", strb, flag_HLT, S_OUT);
      end
      @(posedge clk); #1;
      stop_req = 1'b0;
      @(negedge clk);
      checks++;
      if ({halted, flag_HLT, timeout} !== 3'b100 || cycle_count !== 16'd3 || strb !== 19'h0) begin
         errors++; $display("FAIL stop halt got %b cnt %0d exp 100 3", {halted, flag_HLT, timeout}, cycle_count);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int w; logic [AW-1:0] la;
      words.delete();
      for (int i = 0; i < MW + 3; i++) words.push_back(16'hA000 + 16'(i));
      do_load("burst_max", 1'b0, MW + 3, 1'b1, w, la);
      @(negedge clk);
      checks++;
      if (w != MW || la !== 16'(MW - 1) || busy !== 1'b0) begin
         errors++; $display("FAIL burst_max got %0d/%0d busy %b exp %0d/%0d 0", w, la, busy, MW, MW - 1);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_priority();
      load_start = 1'b1; run_start = 1'b1; load_target = 1'b1;
      @(posedge clk); #1;
      load_start = 1'b0; run_start = 1'b0;
      @(negedge clk);
      checks++;
      if ({ld_ready, dp_clr} !== 2'b10) begin errors++; $display("FAIL priority got %b exp 10", {ld_ready, dp_clr}); end
      @(posedge clk); #1;
      ld_valid = 1'b1; ld_data = 16'hBEEF; ld_last = 1'b1; run_start = 1'b1;
      @(posedge clk); #1;
      ld_valid = 1'b0; ld_last = 1'b0; run_start = 1'b0;
      @(negedge clk);
      checks++;
      if ({ext_data_write_en, ext_data_addr, ext_data_data, ld_ready, dp_clr, busy} !== {1'b1, 16'd0, 16'hBEEF, 3'b000}) begin
         errors++; $display("FAIL priority write got %b %h %h %b", ext_data_write_en, ext_data_addr, ext_data_data,
            {ld_ready, dp_clr, busy});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_clr_mid_run();
      clear_prog();
      for (int i = 0; i < 8; i++) begin prog[i] = 16'hE000; exp_strb[i] = S_OUT; end
      start_run("clr_run");
      run_cycles("clr_run", 2);
      mem_instr_out = 16'hE000; clr = 1'b1; stop_req = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0; stop_req = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, halted, timeout, flag_HLT, dp_clr, ld_ready, ext_instr_we, ext_data_write_en, test_normal} !== 9'b000000001) begin
         errors++; $display("FAIL clr_run flags got %b exp 000000001",
            {busy, halted, timeout, flag_HLT, dp_clr, ld_ready, ext_instr_we, ext_data_write_en, test_normal});
      end
      checks++;
      if (strb !== 19'h0 || cycle_count !== 16'd0 || ext_instr_addr !== 16'd0 || ext_instr_data !== 16'd0
          || ext_data_data !== 16'd0) begin
         errors++; $display("FAIL clr_run values got %h %0d %h %h %h exp all 0", strb, cycle_count,
            ext_instr_addr, ext_instr_data, ext_data_data);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      clr = 1'b1; load_start = 1'b0; load_target = 1'b0; ld_valid = 1'b0; ld_data = 16'h0;
      ld_last = 1'b0; run_start = 1'b0; stop_req = 1'b0; mem_instr_out = 16'h0;
      {Pre_N, Pre_Z, Pre_C, Pre_V} = 4'h0;
      test_reset();
      test_instr_load();
      test_data_run();
      test_branch();
      test_decode();
      test_watchdog();
      test_stop();
      test_back_to_back();
      test_priority();
      test_clr_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
